store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 30 +++
 rtl/store_buffer.sv | 114 +++++++++++
 2 files changed

// File: rtl/store_buffer_pkg.sv
// Shared store-buffer types: funct3 encodings and the buffered entry layout.
// Entry widths track the store_buffer parameter defaults.
package store_buffer_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    logic [2:0]       ctrl;
  } sb_entry_t;

  function automatic logic is_store(
    input logic [2:0] f
  );
    return (f == F3_SB) || (f == F3_SH) ||
           (f == F3_SW);
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Committed-store FIFO between the core and data memory.
// Loads forward from full-word stores or stall until matches drain.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = SB_AW,
  parameter int DATA_WIDTH    = SB_DW,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [ADDRESS_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0]    st_data,
  input  logic [2:0]               st_ctrl,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [2:0]               ld_ctrl,
  output logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_stall,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_writedata,
  output logic [2:0]               mem_memcontrol,
  input  logic [DATA_WIDTH-1:0]    mem_readdata,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  sb_entry_t       q [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   mi;
  logic            match;
  logic            hit;
  logic            push;
  logic            drain;
  sb_entry_t       he;

  assign sb_count = count;
  assign sb_empty = (count == '0);
  assign st_ready = (count != FULL);
  assign push     = st_valid && st_ready &&
                    is_store(st_ctrl);
  assign he       = q[head];

  // Oldest-to-youngest scan: the last hit seen is the youngest match.
  always_comb begin
    match = 1'b0;
    mi    = head;
    idx   = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) &&
          (q[idx].addr[ADDRESS_WIDTH-1:2] ==
           ld_addr[ADDRESS_WIDTH-1:2])) begin
        match = 1'b1;
        mi    = idx;
      end
    end
  end

  assign hit = match && (q[mi].ctrl == F3_SW) &&
               (ld_ctrl == F3_LW);
  assign ld_stall = ld_valid && match && !hit;
  assign ld_data  = hit ? q[mi].data : mem_readdata;
  assign drain    = !sb_empty && (!ld_valid || ld_stall);

  always_comb begin
    mem_we         = 1'b0;
    mem_a          = ld_addr;
    mem_writedata  = '0;
    mem_memcontrol = ld_ctrl;
    if (drain) begin
      mem_we         = 1'b1;
      mem_a          = he.addr;
      mem_writedata  = he.data;
      mem_memcontrol = he.ctrl;
    end
  end

  // Entry payload needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q[tail] <= '{addr: st_addr,
                   data: st_data,
                   ctrl: st_ctrl};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      unique case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
